// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : Bundles the pipeline request/response signals and the
//            data-memory strobe/response signals of mem_access_ctrl.
// Modports : master - the access controller (drives busy/done/fault,
//                     read_data and the memory strobes, address, data)
//            slave  - the environment (pipeline requests and memory
//                     responses)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int WORD = 64
);
    // pipeline side
    logic            req_read;
    logic            req_write;
    logic [WORD-1:0] req_address;
    logic [WORD-1:0] req_write_data;
    logic            busy;
    logic            done;
    logic            fault;
    logic [WORD-1:0] read_data;
    // data-memory side
    logic            mem_read;
    logic            mem_write;
    logic [WORD-1:0] mem_address;
    logic [WORD-1:0] mem_write_data;
    logic [WORD-1:0] mem_read_data;
    logic            mem_ready;

    modport master (
        input  req_read, req_write, req_address, req_write_data,
        input  mem_read_data, mem_ready,
        output busy, done, fault, read_data,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        output req_read, req_write, req_address, req_write_data,
        output mem_read_data, mem_ready,
        input  busy, done, fault, read_data,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Initiator side of the data-memory interface. Accepts one
//            doubleword load or store at a time, drives the memory strobe
//            until mem_ready (or a timeout), captures load data and stalls
//            the pipeline while the access is in flight. Misaligned,
//            conflicting and timed-out requests complete with fault=1.
// Ports    : clk   - system clock, rising edge
//            rst_n - synchronous reset, active-low
//            bus   - mem_access_ctrl_if.master (requests, busy/done/fault,
//                    read_data, memory strobes/address/data, mem_ready)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 16   // legal range 1..255
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_access_ctrl_if.master  bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    // Count value on the last permitted ACCESS cycle: the counter reads 0 in
    // the first strobe cycle, so the strobe stays up for exactly TIMEOUT cycles.
    localparam logic [7:0] c_CNT_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_fault;
    logic [WORD-1:0] r_read_data;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [WORD-1:0] r_mem_address;
    logic [WORD-1:0] r_mem_write_data;

    logic w_req_any;
    logic w_req_ok;

    assign w_req_any = bus.req_read | bus.req_write;
    // exactly one request, doubleword aligned
    assign w_req_ok  = (bus.req_read ^ bus.req_write) && (bus.req_address[2:0] == 3'b000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= c_ST_IDLE;
            r_cnt            <= 8'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_fault          <= 1'b0;
            r_read_data      <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req_ok) begin
                        r_mem_address    <= bus.req_address;
                        r_mem_write_data <= bus.req_write_data;
                        r_mem_read       <= bus.req_read;
                        r_mem_write      <= bus.req_write;
                        r_busy           <= 1'b1;
                        r_cnt            <= 8'd0;
                        r_state          <= c_ST_ACCESS;
                    end else if (w_req_any) begin
                        // rejected request: no strobe, straight to the response cycle
                        r_busy  <= 1'b1;
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                        r_state <= c_ST_RESP;
                    end
                end

                c_ST_ACCESS: begin
                    // ready wins over the timeout limit in the same cycle
                    if (bus.mem_ready) begin
                        if (r_mem_read) begin
                            r_read_data <= bus.mem_read_data;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_done      <= 1'b1;
                        r_fault     <= 1'b0;
                        r_state     <= c_ST_RESP;
                    end else if (r_cnt == c_CNT_LIMIT) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_done      <= 1'b1;
                        r_fault     <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                c_ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.fault          = r_fault;
    assign bus.read_data      = r_read_data;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_write_data;

endmodule
`default_nettype wire
